// File: rtl/spi_pkg.sv
// Shared definitions for the SPI sensor arbiter and its helpers.
package spi_pkg;

    localparam int unsigned SPI_DW = 32;

    // Receive word substituted when the watchdog aborts a transaction (all fault bits set).
    localparam logic [SPI_DW-1:0] SPI_TIMEOUT_WORD = 32'h0000_0007;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } spi_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr+1, wrapping mod N.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] winner
);

    // Walk candidates from farthest to nearest so the nearest hit is written last.
    always_comb begin
        logic [SELW-1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = int'(N); k >= 1; k--) begin
            cand = SELW'((int'(ptr) + k) % int'(N));
            if (req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/spi_sensor_arbiter.sv
// Round-robin sharing of one SPI master among N sensor readers, with stall watchdog.
module spi_sensor_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned SELW    = 2,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TBITS   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    output logic [N-1:0]      grant,
    output logic [N-1:0]      done,
    output logic [SPI_DW-1:0] rx_data,
    output logic              timeout_err,
    output logic              spi_ena,
    input  logic              spi_not_busy,
    input  logic [SPI_DW-1:0] spi_rx_data,
    output logic [SELW-1:0]   spi_cs_sel
);

    spi_state_e        state, state_nxt;
    logic [SELW-1:0]   ptr, ptr_nxt;
    logic [TBITS-1:0]  wd, wd_nxt;
    logic              to_flag, to_flag_nxt;
    logic [N-1:0]      grant_nxt, done_nxt;
    logic [SPI_DW-1:0] rx_data_nxt;
    logic              timeout_err_nxt, spi_ena_nxt;
    logic [SELW-1:0]   spi_cs_sel_nxt;
    logic              pick_found;
    logic [SELW-1:0]   pick_idx;
    logic              wd_expired;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .found  (pick_found),
        .winner (pick_idx)
    );

    // State, pointer, watchdog and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= SELW'(N - 1);
            wd          <= '0;
            to_flag     <= 1'b0;
            grant       <= '0;
            done        <= '0;
            rx_data     <= '0;
            timeout_err <= 1'b0;
            spi_ena     <= 1'b0;
            spi_cs_sel  <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            wd          <= wd_nxt;
            to_flag     <= to_flag_nxt;
            grant       <= grant_nxt;
            done        <= done_nxt;
            rx_data     <= rx_data_nxt;
            timeout_err <= timeout_err_nxt;
            spi_ena     <= spi_ena_nxt;
            spi_cs_sel  <= spi_cs_sel_nxt;
        end
    end

    // Next-state and next-output logic; the handshake always beats the watchdog.
    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        wd_nxt          = wd;
        to_flag_nxt     = to_flag;
        grant_nxt       = grant;
        done_nxt        = '0;
        rx_data_nxt     = rx_data;
        timeout_err_nxt = 1'b0;
        spi_ena_nxt     = spi_ena;
        spi_cs_sel_nxt  = spi_cs_sel;
        wd_expired      = (wd == TBITS'(TIMEOUT - 1));

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt      = START;
                    ptr_nxt        = pick_idx;
                    grant_nxt      = N'(1) << pick_idx;
                    spi_cs_sel_nxt = pick_idx;
                    spi_ena_nxt    = 1'b1;
                    wd_nxt         = '0;
                    to_flag_nxt    = 1'b0;
                end
            end
            START: begin
                wd_nxt = wd + TBITS'(1);
                if (!spi_not_busy) begin
                    spi_ena_nxt = 1'b0;
                    state_nxt   = SHIFT;
                end else if (wd_expired) begin
                    spi_ena_nxt = 1'b0;
                    rx_data_nxt = SPI_TIMEOUT_WORD;
                    to_flag_nxt = 1'b1;
                    state_nxt   = FINISH;
                end
            end
            SHIFT: begin
                wd_nxt = wd + TBITS'(1);
                if (spi_not_busy) begin
                    rx_data_nxt = spi_rx_data;
                    state_nxt   = FINISH;
                end else if (wd_expired) begin
                    spi_ena_nxt = 1'b0;
                    rx_data_nxt = SPI_TIMEOUT_WORD;
                    to_flag_nxt = 1'b1;
                    state_nxt   = FINISH;
                end
            end
            FINISH: begin
                done_nxt        = N'(1) << ptr;
                timeout_err_nxt = to_flag;
                to_flag_nxt     = 1'b0;
                grant_nxt       = '0;
                state_nxt       = IDLE;
            end
            default: begin
                state_nxt      = IDLE;
                grant_nxt      = '0;
                spi_ena_nxt    = 1'b0;
                spi_cs_sel_nxt = '0;
                to_flag_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/spi_sensor_arbiter.md
# spi_sensor_arbiter

Round-robin arbiter and sequencer that shares one SPI master among up to N sensor-reader clients (thermocouple, junction/ambient, spare channels). It grants one client at a time and drives the master's enable/busy handshake. It captures the 32-bit receive word and returns it to the granted client with a one-cycle done pulse. A watchdog releases the bus if the master stalls. It sits between the reader FSMs and the single SPI master instance.

## Interface
- N, 4, number of requesters (2..8)
- SELW, 2, width of chip-select index, ceil(log2(N))
- TIMEOUT, 1023, max cycles in any wait state before abort
- TBITS, 10, watchdog counter width, 2^TBITS > TIMEOUT

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  N  per-client request level; held high until that client's done
- grant  out  N  one-hot, registered; bit i high for the whole transaction of client i
- done  out  N  one-cycle pulse to granted client; rx_data valid that cycle
- rx_data  out  32  captured spi_rx_data of last completed transaction
- timeout_err  out  1  one-cycle pulse on watchdog abort (done also pulses)
- spi_ena  out  1  start request to SPI master
- spi_not_busy  in  1  master idle flag (low while shifting)
- spi_rx_data  in  32  master receive word, stable once spi_not_busy returns high
- spi_cs_sel  out  SELW  index of granted client; selects chip-select mux

## Operation
- States: IDLE, START, SHIFT, FINISH.
- IDLE: if any req bit is high, select the winner by round-robin search starting at ptr+1 mod N. Register grant, spi_cs_sel and ptr=winner. Clear the watchdog. Go to START.
- START: spi_ena=1. When spi_not_busy==0, spi_ena=0 and go to SHIFT.
- SHIFT: wait for spi_not_busy==1, then rx_data<=spi_rx_data and go to FINISH.
- FINISH: done[ptr]=1 for one cycle. Clear grant. Go to IDLE.
- Watchdog: counts every cycle in START or SHIFT. On reaching TIMEOUT:
  - spi_ena=0 and rx_data <= 32'h0000_0007 (all fault bits set).
  - timeout_err=1 together with the FINISH done pulse.
  - FINISH then proceeds as normal.
- Dropped request: req[ptr] falling mid-transaction does not abort. The transaction completes and done still pulses.
- Ignored requests: req bits of non-granted clients are ignored until IDLE.
- Undefined state encoding: go to IDLE with all outputs deasserted.
- Reset values:
  - grant=0, done=0, rx_data=0, timeout_err=0, spi_ena=0, spi_cs_sel=0, state=IDLE.
  - ptr=N-1, so client 0 wins first.
- Reset mid-transaction: all outputs return to their reset values the next cycle. No done pulse is issued for the aborted client.

## Timing
- From req rising in IDLE:
  - grant and spi_cs_sel are high on the next edge.
  - spi_ena is high from the same edge, since START is registered combined with grant.
- spi_ena falls on the edge after spi_not_busy is sampled low.
- rx_data updates on the edge after spi_not_busy is sampled high again. done pulses in the following cycle.
- Minimum transaction is 4 cycles from grant to done.
- Back-to-back: after FINISH, IDLE can grant on the next cycle, giving one idle cycle between transactions.
- Fairness: with all N requests held, grants rotate 0,1,..,N-1,0. No client waits more than N-1 transactions.
- Simultaneous events:
  - spi_not_busy high at the same cycle as timeout in SHIFT: the normal capture wins and timeout_err stays 0.
  - In START, the handshake wins over timeout when both occur in the same cycle.

## Structure
- A shared package spi_pkg holds:
  - the state enum (IDLE/START/SHIFT/FINISH);
  - the fault constant SPI_TIMEOUT_WORD = 32'h0000_0007;
  - the data width constant SPI_DW = 32.
- One sub-module is natural: rr_pick (N). It is combinational: inputs req, ptr; outputs found and the winner index. It is reused by other arbiters in the codebase.
- The watchdog counter and FSM stay in the top-level module.

## Test plan
- Single client: req=4'b0001, master drops busy 2 cycles after spi_ena and returns after 32 cycles with 32'hDEAD_BEEF.
  -> grant=0001, spi_cs_sel=0, done[0] pulses once, rx_data=DEADBEEF, timeout_err=0.
- Contention: req=4'b1111 held for 5 transactions.
  -> grant order 0,1,2,3,0; exactly one done per transaction; one idle cycle between transactions.
- Late arrival: client 2 transacting, client 1 raises req mid-SHIFT.
  -> client 1 is not granted until after done[2], then granted next; spi_cs_sel=1.
- Timeout: spi_not_busy held high forever after grant.
  -> at TIMEOUT cycles spi_ena=0; done and timeout_err pulse together; rx_data=00000007; bus returns to IDLE.
- Dropped request: req[3] falls during SHIFT.
  -> transaction completes and done[3] still pulses.
- Reset in SHIFT: rst for 1 cycle.
  -> next cycle grant=0, spi_ena=0, rx_data=0, no done pulse; the next grant with req=1111 goes to client 0.
